// File: rtl/alu_multicycle_unit.sv
// alu_multicycle_unit
//   RV32 EX-stage ALU. RV32I integer ops complete in one cycle. MUL, MULHU,
//   DIVU and REMU iterate one bit per cycle for WIDTH cycles. Operands and
//   results move through valid/ready handshakes so the pipeline can stall.
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operands/op presented
//   in_ready   unit can accept (IDLE only)
//   in_a       operand A (dividend / multiplicand)
//   in_b       operand B (divisor / multiplier / shift amount)
//   in_op      operation select
//   out_valid  result available (DONE only)
//   out_ready  consumer takes result
//   out_result result, held stable until taken
//   out_zero   out_result == 0
module alu_multicycle_unit #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = OP_W'(0),
    OP_SUB   = OP_W'(1),
    OP_AND   = OP_W'(2),
    OP_OR    = OP_W'(3),
    OP_XOR   = OP_W'(4),
    OP_SLL   = OP_W'(5),
    OP_SRL   = OP_W'(6),
    OP_SRA   = OP_W'(7),
    OP_SLT   = OP_W'(8),
    OP_SLTU  = OP_W'(9),
    OP_MUL   = OP_W'(10),
    OP_MULHU = OP_W'(11),
    OP_DIVU  = OP_W'(12),
    OP_REMU  = OP_W'(13)
  } op_e;

  state_e             state_q, state_d;
  op_e                op_in;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   result_q;
  logic [2*WIDTH-1:0] acc_q, acc_next;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_mul_q;
  logic               hi_sel_q;
  logic               iter_op;
  logic               last_iter;
  logic [SH_W-1:0]    shamt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;

  assign op_in      = op_e'(in_op);
  assign shamt      = in_b[SH_W-1:0];
  assign last_iter  = (cnt_q == CNT_W'(WIDTH - 1));
  assign out_result = result_q;
  assign out_zero   = (result_q == '0);

  always_comb begin
    iter_op = (op_in == OP_MUL) || (op_in == OP_MULHU) ||
              (op_in == OP_DIVU) || (op_in == OP_REMU);
  end

  // Next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = iter_op ? S_BUSY : S_DONE;
      end
      S_BUSY: begin
        if (last_iter) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Single-cycle operations
  always_comb begin
    alu_res = '0;
    case (op_in)
      OP_ADD:  alu_res = in_a + in_b;
      OP_SUB:  alu_res = in_a - in_b;
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SLL:  alu_res = in_a << shamt;
      OP_SRL:  alu_res = in_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(in_a) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      default: alu_res = '0;
    endcase
  end

  // One iteration step. acc holds {high, low} halves:
  //   multiply: {partial product, remaining multiplier bits}, shift right
  //   divide:   {remainder, dividend bits becoming quotient}, shift left
  // A zero divisor always "fits", giving all-ones quotient and the dividend
  // as remainder, which is exactly the RISC-V divide-by-zero result.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    if (is_mul_q)
      acc_next = {mul_sum, acc_q[WIDTH-1:1]};
    else if (!div_trial[WIDTH])
      acc_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      acc_next = {acc_q[2*WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      is_mul_q <= 1'b0;
      hi_sel_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (iter_op) begin
              is_mul_q <= (op_in == OP_MUL) || (op_in == OP_MULHU);
              // MULHU and REMU take the upper half of the accumulator
              hi_sel_q <= (op_in == OP_MULHU) || (op_in == OP_REMU);
              cnt_q    <= '0;
              if ((op_in == OP_MUL) || (op_in == OP_MULHU)) begin
                opnd_q <= in_a;
                acc_q  <= {{WIDTH{1'b0}}, in_b};
              end else begin
                opnd_q <= in_b;
                acc_q  <= {{WIDTH{1'b0}}, in_a};
              end
            end else begin
              result_q <= alu_res;
            end
          end
        end
        S_BUSY: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter)
            result_q <= hi_sel_q ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle_unit.sv
// tb_alu_multicycle_unit
//   Directed self-checking bench for alu_multicycle_unit (WIDTH=32).
module tb_alu_multicycle_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_multicycle_unit #(.WIDTH(32), .OP_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op with out_ready high, check latency, result, zero flag,
  // and the return to IDLE one cycle after the result is taken.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    chk({tag, "_ready_before"}, in_ready, 1);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_result"}, out_result, exp);
    chk({tag, "_zero"}, out_zero, (exp == 32'd0));
    chk({tag, "_ready_done"}, in_ready, 0);
    tick();
    chk({tag, "_valid_after"}, out_valid, 0);
    chk({tag, "_ready_after"}, in_ready, 1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", out_result, 32'h0);
    chk("rst_zero", out_zero, 1);

    // Single-cycle ops
    run_op("add", 4'h0, 32'd15, 32'd4, 32'd19, 1);
    run_op("sub", 4'h1, 32'd4, 32'd4, 32'd0, 1);
    run_op("sra", 4'h7, 32'h8000_0000, 32'h24, 32'hF800_0000, 1);
    run_op("srl", 4'h6, 32'h8000_0000, 32'h24, 32'h0800_0000, 1);
    run_op("sll", 4'h5, 32'h0000_0003, 32'h1F, 32'h8000_0000, 1);
    run_op("slt", 4'h8, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_op("sltu", 4'h9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run_op("xor", 4'h4, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 1);
    run_op("rsvd", 4'hE, 32'd7, 32'd9, 32'd0, 1);

    // Iterative ops
    run_op("mul", 4'hA, 32'd15, 32'd4, 32'd60, 33);
    run_op("mulhu", 4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mul_lo", 4'hA, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 33);
    run_op("divu", 4'hC, 32'd15, 32'd4, 32'd3, 33);
    run_op("remu", 4'hD, 32'd15, 32'd4, 32'd3, 33);
    run_op("divu0", 4'hC, 32'd15, 32'd0, 32'hFFFF_FFFF, 33);
    run_op("remu0", 4'hD, 32'd15, 32'd0, 32'd15, 33);
    run_op("divu_big", 4'hC, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 33);

    // Result held under back-pressure; new ops ignored
    in_op = 4'h0; in_a = 32'd15; in_b = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_op = 4'h1;
    for (int i = 0; i < 5; i++) begin
      in_a = 32'd100 + i; in_b = 32'd1;
      chk("hold_valid", out_valid, 1);
      chk("hold_result", out_result, 32'd19);
      chk("hold_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("hold_release_valid", out_valid, 0);
    chk("hold_release_ready", in_ready, 1);
    in_valid = 1'b0;
    tick();
    chk("hold_no_reaccept", out_valid, 0);

    // Reset while in DONE
    in_op = 4'h0; in_a = 32'd1; in_b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("done_valid_pre", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("done_rst_valid", out_valid, 0);
    chk("done_rst_ready", in_ready, 1);

    // Reset at cycle 10 of DIVU
    out_ready = 1'b1;
    in_op = 4'hC; in_a = 32'd15; in_b = 32'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    chk("busy_ready", in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("busy_rst_valid", out_valid, 0);
    chk("busy_rst_ready", in_ready, 1);
    seen = 0;
    repeat (40) begin
      if (out_valid) seen = 1;
      tick();
    end
    chk("busy_rst_no_pulse", seen, 0);
    run_op("add_post_rst", 4'h0, 32'd1, 32'd2, 32'd3, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
